bpred_resolve: RTL and testbench

- Resolution-side companion of bpred. It closes the predictor loop by producing the update_* interface that bpred consumes.
- Fetch enqueues each branch's prediction (bpred outputs plus neip) into an in-order branch queue.
- Execute supplies the actual outcome. The block pops the oldest entry, detects a mispredict, drives the bpred update and a fetch redirect, and flushes younger entries on a mispredict.

---
 rtl/bpred_pkg.sv | 25 ++
 rtl/bpred_queue.sv | 63 ++++++
 rtl/bpred_resolve.sv | 124 ++++++++++++
 tb/tb_bpred_resolve.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared branch-queue entry type and the mispredict compare used on the resolve path.
package bpred_pkg;

    localparam int AW_DEFAULT = 32;

    typedef struct packed {
        logic [AW_DEFAULT-1:0] neip;
        logic                  pred_taken;
        logic [AW_DEFAULT-1:0] pred_target;
        logic                  pred_hit;
    } bq_entry_t;

    // A BTB miss is treated as a not-taken prediction.
    function automatic logic is_mispredict(
        input bq_entry_t             e,
        input logic                  res_taken,
        input logic [AW_DEFAULT-1:0] res_target
    );
        logic eff_taken;
        eff_taken = e.pred_hit & e.pred_taken;
        return (eff_taken != res_taken) ||
               (eff_taken && res_taken && (e.pred_target != res_target));
    endfunction

endpackage

// File: rtl/bpred_queue.sv
// In-order circular FIFO with occupancy count and a flush that discards everything left after a pop.
module bpred_queue #(
    parameter int DEPTH = 8,
    parameter int W     = 66
)(
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [W-1:0]           enq_data,
    input  logic                   deq,
    output logic                   deq_ready,
    output logic [W-1:0]           deq_data,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [PW-1:0]   head_next;
    logic [CW-1:0]   count_reg;
    logic            push;
    logic            pop;

    assign enq_ready = (count_reg != FULL_COUNT);
    assign deq_ready = (count_reg != '0);
    assign occupancy = count_reg;
    assign deq_data  = mem[head_reg];

    // A flush also drops a same-cycle enqueue: it belongs to the wrong path.
    assign push      = enq_valid & enq_ready & ~flush;
    assign pop       = deq & deq_ready;
    assign head_next = head_reg + PW'(pop);

    always_ff @(posedge CLK) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg <= head_next;
            if (flush) begin
                tail_reg  <= head_next;
                count_reg <= '0;
            end else begin
                tail_reg  <= tail_reg + PW'(push);
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail_reg] <= enq_data;
        end
    end

endmodule

// File: rtl/bpred_resolve.sv
// Pops predicted branches in order, compares against execute's outcome and drives bpred update + fetch redirect.
// Optional counters: define BPRED_RESOLVE_STATS_EN to add stat_branches / stat_mispreds.
module bpred_resolve
    import bpred_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = AW_DEFAULT
)(
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [AW-1:0]          enq_neip,
    input  logic                   enq_pred_taken,
    input  logic [AW-1:0]          enq_pred_target,
    input  logic                   enq_pred_hit,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic                   res_taken,
    input  logic [AW-1:0]          res_target,
    output logic [AW-1:0]          update_neip,
    output logic [AW-1:0]          update_target,
    output logic                   update_taken,
    output logic                   update_mispred,
    output logic                   update_valid,
    output logic                   redirect_valid,
    output logic [AW-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef BPRED_RESOLVE_STATS_EN
    ,
    output logic [31:0]            stat_branches,
    output logic [31:0]            stat_mispreds
`endif
);

    bq_entry_t enq_entry;
    bq_entry_t head_entry;
    logic      fire;
    logic      mispred;

    logic [AW-1:0] update_neip_reg;
    logic [AW-1:0] update_target_reg;
    logic          update_taken_reg;
    logic          update_mispred_reg;
    logic          update_valid_reg;
    logic          redirect_valid_reg;
    logic [AW-1:0] redirect_pc_reg;

    assign enq_entry = '{neip: enq_neip, pred_taken: enq_pred_taken,
                         pred_target: enq_pred_target, pred_hit: enq_pred_hit};

    bpred_queue #(
        .DEPTH (DEPTH),
        .W     ($bits(bq_entry_t))
    ) u_queue (
        .CLK       (CLK),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_data  (enq_entry),
        .deq       (res_valid),
        .deq_ready (res_ready),
        .deq_data  (head_entry),
        .flush     (fire & mispred),
        .occupancy (occupancy)
    );

    assign fire    = res_valid & res_ready;
    assign mispred = is_mispredict(head_entry, res_taken, res_target);

    // Correctly predicted not-taken branches carry no new information for bpred.
    always_ff @(posedge CLK) begin
        if (reset) begin
            update_neip_reg    <= '0;
            update_target_reg  <= '0;
            update_taken_reg   <= 1'b0;
            update_mispred_reg <= 1'b0;
            update_valid_reg   <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            update_valid_reg   <= fire & (mispred | res_taken);
            redirect_valid_reg <= fire & mispred;
            if (fire) begin
                update_neip_reg    <= head_entry.neip;
                update_target_reg  <= res_target;
                update_taken_reg   <= res_taken;
                update_mispred_reg <= mispred;
                redirect_pc_reg    <= res_taken ? res_target : head_entry.neip;
            end
        end
    end

    assign update_neip    = update_neip_reg;
    assign update_target  = update_target_reg;
    assign update_taken   = update_taken_reg;
    assign update_mispred = update_mispred_reg;
    assign update_valid   = update_valid_reg;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;

`ifdef BPRED_RESOLVE_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispreds_reg;

    always_ff @(posedge CLK) begin
        if (reset) begin
            stat_branches_reg <= '0;
            stat_mispreds_reg <= '0;
        end else begin
            if (fire && (stat_branches_reg != '1)) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (fire && mispred && (stat_mispreds_reg != '1)) begin
                stat_mispreds_reg <= stat_mispreds_reg + 32'd1;
            end
        end
    end

    assign stat_branches = stat_branches_reg;
    assign stat_mispreds = stat_mispreds_reg;
`endif

endmodule

// File: tb/tb_bpred_resolve.sv
// Self-checking bench for bpred_resolve: vector table plus hand sequences, checked through a scoreboard queue.
module tb_bpred_resolve;
    import bpred_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = AW_DEFAULT;

    logic          CLK = 1'b0;
    logic          reset;
    logic          enq_valid;
    logic          enq_ready;
    logic [AW-1:0] enq_neip;
    logic          enq_pred_taken;
    logic [AW-1:0] enq_pred_target;
    logic          enq_pred_hit;
    logic          res_valid;
    logic          res_ready;
    logic          res_taken;
    logic [AW-1:0] res_target;
    logic [AW-1:0] update_neip;
    logic [AW-1:0] update_target;
    logic          update_taken;
    logic          update_mispred;
    logic          update_valid;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [3:0]    occupancy;
`ifdef BPRED_RESOLVE_STATS_EN
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispreds;
`endif

    always #5 CLK = ~CLK;

    bpred_resolve #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK             (CLK),
        .reset           (reset),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_neip        (enq_neip),
        .enq_pred_taken  (enq_pred_taken),
        .enq_pred_target (enq_pred_target),
        .enq_pred_hit    (enq_pred_hit),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .update_neip     (update_neip),
        .update_target   (update_target),
        .update_taken    (update_taken),
        .update_mispred  (update_mispred),
        .update_valid    (update_valid),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .occupancy       (occupancy)
`ifdef BPRED_RESOLVE_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispreds   (stat_mispreds)
`endif
    );

    typedef struct {
        logic [AW-1:0] neip;
        logic [AW-1:0] target;
        logic          taken;
        logic          mispred;
        logic          uvalid;
        logic          rvalid;
        logic [AW-1:0] rpc;
    } exp_t;

    typedef struct {
        bq_entry_t     pred;
        logic          rt;
        logic [AW-1:0] rtg;
        logic          mis;
        logic          uv;
        logic [AW-1:0] rpc;
    } vec_t;

    exp_t      sb_q[$];
    bq_entry_t model_q[$];
    vec_t      tbl[7];
    bq_entry_t idle;
    int        n_checks = 0;
    int        n_errors = 0;

    function automatic bq_entry_t mk(input logic [AW-1:0] n, input logic t,
                                     input logic [AW-1:0] tg, input logic h);
        bq_entry_t e;
        e.neip = n; e.pred_taken = t; e.pred_target = tg; e.pred_hit = h;
        return e;
    endfunction

    function automatic vec_t vec(input bq_entry_t p, input logic rt, input logic [AW-1:0] rtg,
                                 input logic mis, input logic uv, input logic [AW-1:0] rpc);
        vec_t v;
        v.pred = p; v.rt = rt; v.rtg = rtg; v.mis = mis; v.uv = uv; v.rpc = rpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check ready/occupancy against the model, advance the model,
    // then after the edge compare registered outputs with the scoreboard.
    task automatic cycle(input logic rst, input logic ev, input bq_entry_t e,
                         input logic rv, input logic rt, input logic [AW-1:0] rtg);
        logic      exp_er, exp_rr, efire, rfire, mis;
        bq_entry_t h;
        exp_t      x;
        exp_er = (model_q.size() != DEPTH);
        exp_rr = (model_q.size() != 0);
        reset = rst;
        enq_valid = ev; enq_neip = e.neip; enq_pred_taken = e.pred_taken;
        enq_pred_target = e.pred_target; enq_pred_hit = e.pred_hit;
        res_valid = rv; res_taken = rt; res_target = rtg;
        chk("enq_ready", 64'(enq_ready), 64'(exp_er));
        chk("res_ready", 64'(res_ready), 64'(exp_rr));
        chk("occupancy", 64'(occupancy), 64'(model_q.size()));
        efire = ev & exp_er;
        rfire = rv & exp_rr;
        mis = 1'b0;
        if (rst) begin
            model_q.delete();
            $display("reset cycle");
        end else begin
            if (rfire) begin
                h = model_q.pop_front();
                mis = is_mispredict(h, rt, rtg);
                x.neip = h.neip; x.target = rtg; x.taken = rt; x.mispred = mis;
                x.uvalid = mis | rt; x.rvalid = mis; x.rpc = rt ? rtg : h.neip;
                sb_q.push_back(x);
                $display("resolve neip=0x%0h taken=%0b target=0x%0h mispred=%0b", h.neip, rt, rtg, mis);
            end
            if (mis) model_q.delete();
            else if (efire) begin
                model_q.push_back(e);
                $display("enqueue neip=0x%0h hit=%0b taken=%0b target=0x%0h",
                         e.neip, e.pred_hit, e.pred_taken, e.pred_target);
            end
        end
        @(posedge CLK);
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk("update_valid", 64'(update_valid), 64'(x.uvalid));
            chk("update_neip", 64'(update_neip), 64'(x.neip));
            chk("update_target", 64'(update_target), 64'(x.target));
            chk("update_taken", 64'(update_taken), 64'(x.taken));
            chk("update_mispred", 64'(update_mispred), 64'(x.mispred));
            chk("redirect_valid", 64'(redirect_valid), 64'(x.rvalid));
            chk("redirect_pc", 64'(redirect_pc), 64'(x.rpc));
        end else begin
            chk("idle_update_valid", 64'(update_valid), 64'd0);
            chk("idle_redirect_valid", 64'(redirect_valid), 64'd0);
        end
    endtask

    initial begin
        idle = mk(32'd0, 1'b0, 32'd0, 1'b0);
        tbl[0] = vec(mk(32'd16, 1'b0, 32'd0,   1'b0), 1'b1, 32'd45,  1'b1, 1'b1, 32'd45);
        tbl[1] = vec(mk(32'd16, 1'b1, 32'd45,  1'b1), 1'b1, 32'd45,  1'b0, 1'b1, 32'd45);
        tbl[2] = vec(mk(32'd20, 1'b0, 32'd0,   1'b1), 1'b0, 32'd0,   1'b0, 1'b0, 32'd20);
        tbl[3] = vec(mk(32'd24, 1'b1, 32'd99,  1'b0), 1'b0, 32'd0,   1'b0, 1'b0, 32'd24);
        tbl[4] = vec(mk(32'd32, 1'b1, 32'd100, 1'b1), 1'b1, 32'd104, 1'b1, 1'b1, 32'd104);
        tbl[5] = vec(mk(32'd40, 1'b1, 32'd50,  1'b1), 1'b0, 32'd0,   1'b1, 1'b1, 32'd40);
        tbl[6] = vec(mk(32'd48, 1'b1, 32'd60,  1'b0), 1'b1, 32'd60,  1'b1, 1'b1, 32'd60);

        reset = 1'b1;
        enq_valid = 1'b0; enq_neip = '0; enq_pred_taken = 1'b0; enq_pred_target = '0; enq_pred_hit = 1'b0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_res_ready", 64'(res_ready), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_update_valid", 64'(update_valid), 64'd0);
        chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("rst_update_neip", 64'(update_neip), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);

        // Single-branch vectors
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, tbl[i].pred, 1'b0, 1'b0, 32'd0);
            cycle(1'b0, 1'b0, idle, 1'b1, tbl[i].rt, tbl[i].rtg);
            chk("tbl_mispred", 64'(update_mispred), 64'(tbl[i].mis));
            chk("tbl_update_valid", 64'(update_valid), 64'(tbl[i].uv));
            chk("tbl_redirect_pc", 64'(redirect_pc), 64'(tbl[i].rpc));
            chk("tbl_occupancy", 64'(occupancy), 64'd0);
        end

        // Mispredict at the head flushes three younger entries
        cycle(1'b0, 1'b1, mk(32'd64, 1'b1, 32'd25, 1'b1), 1'b0, 1'b0, 32'd0);
        for (int i = 1; i < 4; i++)
            cycle(1'b0, 1'b1, mk(32'd64 + 32'(4 * i), 1'b0, 32'd0, 1'b0), 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b0, 32'd0);
        chk("flush_redirect_pc", 64'(redirect_pc), 64'd64);
        chk("flush_occupancy", 64'(occupancy), 64'd0);

        // Fill, overflow attempt, then drain in order across the wrap
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 1'b1, mk(32'h100 + 32'(4 * i), 1'b0, 32'd0, 1'b0), 1'b0, 1'b0, 32'd0);
        chk("full_enq_ready", 64'(enq_ready), 64'd0);
        cycle(1'b0, 1'b1, mk(32'h1f0, 1'b0, 32'd0, 1'b0), 1'b0, 1'b0, 32'd0);
        chk("full_occupancy", 64'(occupancy), 64'd8);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, (i == 0), mk(32'h200, 1'b0, 32'd0, 1'b0), 1'b1, 1'b0, 32'd0);
            chk("drain_order_neip", 64'(update_neip), 64'(32'h100 + 32'(4 * i)));
        end
        chk("drained_res_ready", 64'(res_ready), 64'd0);

        // Resolve while empty does nothing
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b1, 32'h77);
        chk("empty_update_neip_held", 64'(update_neip), 64'(32'h11c));

        // Same-cycle enqueue + mispredicting resolve drops the new entry
        cycle(1'b0, 1'b1, mk(32'h300, 1'b0, 32'd0, 1'b0), 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, mk(32'h400, 1'b0, 32'd0, 1'b0), 1'b1, 1'b1, 32'h500);
        chk("drop_occupancy", 64'(occupancy), 64'd0);
        chk("drop_redirect_pc", 64'(redirect_pc), 64'h500);

        // Same-cycle enqueue + correct resolve keeps occupancy constant
        cycle(1'b0, 1'b1, mk(32'h310, 1'b0, 32'd0, 1'b0), 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, mk(32'h320, 1'b0, 32'd0, 1'b0), 1'b1, 1'b0, 32'd0);
        chk("swap_occupancy", 64'(occupancy), 64'd1);
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b0, 32'd0);
        chk("swap_second_neip", 64'(update_neip), 64'h320);

        // Reset on the edge that would register a resolve suppresses the pulse
        cycle(1'b0, 1'b1, mk(32'h600, 1'b1, 32'h700, 1'b1), 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, idle, 1'b1, 1'b1, 32'h700);
        chk("rst_pulse_update_valid", 64'(update_valid), 64'd0);
        chk("rst_pulse_occupancy", 64'(occupancy), 64'd0);
        chk("rst_pulse_update_neip", 64'(update_neip), 64'd0);
        cycle(1'b0, 1'b1, mk(32'h800, 1'b1, 32'h900, 1'b1), 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b1, 32'h900);
        cycle(1'b0, 1'b0, idle, 1'b0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
